// File: rtl/cpu_pkg.sv
// Shared definitions for the decode stage: opcode map, pipeline FSM encoding
// and the decoded control bundle carried from decode into execute.
package cpu_pkg;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_BR    = 4'b0010;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_ST    = 4'b0111;
  localparam logic [3:0] OP_LD    = 4'b1000;
  localparam logic [3:0] OP_ALUR0 = 4'b1010;
  localparam logic [3:0] OP_ALUR1 = 4'b1011;
  localparam logic [3:0] OP_ALUI0 = 4'b1100;
  localparam logic [3:0] OP_ALUI1 = 4'b1101;
  localparam logic [3:0] OP_ALUI2 = 4'b1110;
  localparam logic [3:0] OP_ALUI3 = 4'b1111;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic [2:0] rd_rq;
    logic [2:0] rs;
    logic       write_en;
    logic       jb;
    logic       imm_sel;
    logic       rs_or_imm;
    logic [3:0] alu_ctrl;
    logic       mem_wr;
    logic       mem_rd;
  } id_ctrl_t;

  // Register field that the hazard check and the ID bundle treat as rd/rq.
  function automatic logic [2:0] sel_rd_rq(input logic [15:0] inst);
    return inst[14] ? inst[11:9] : inst[5:3];
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Purely combinational instruction decode: control bundle and next-PC
// selection from one 16-bit instruction word.
module decode_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = 13
) (
  input  logic [15:0]     inst,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] pc_plus2,
  output id_ctrl_t        ctrl,
  output logic [PC_W-1:0] pc_next
);

  logic [3:0] opcode_s;

  assign opcode_s = inst[15:12];

  // Field extraction, opcode classification and ALU operation select.
  always_comb begin
    ctrl           = '0;
    ctrl.rd_rq     = sel_rd_rq(inst);
    ctrl.rs        = inst[8:6];
    ctrl.write_en  = inst[15];
    ctrl.jb        = (opcode_s == OP_JMP) || (opcode_s == OP_BR);
    ctrl.imm_sel   = (opcode_s == OP_LD) || (opcode_s == OP_ST);
    ctrl.rs_or_imm = inst[13];
    ctrl.mem_wr    = (opcode_s == OP_ST);
    ctrl.mem_rd    = (opcode_s == OP_LD);
    case (opcode_s)
      OP_ALUI0: ctrl.alu_ctrl = 4'b0000;
      OP_ALUI1: ctrl.alu_ctrl = 4'b0001;
      OP_ALUI2: ctrl.alu_ctrl = 4'b0010;
      OP_ALUI3: ctrl.alu_ctrl = 4'b0011;
      // A zero sub-op field in this group selects operation 8.
      OP_ALUR1: ctrl.alu_ctrl = (inst[2:0] != 3'b000) ? {1'b0, inst[2:0]} : 4'b1000;
      OP_ALUR0: ctrl.alu_ctrl = {1'b1, inst[2:0]};
      default:  ctrl.alu_ctrl = 4'b0000;
    endcase
    pc_next = (opcode_s == OP_HALT) ? pc : pc_plus2;
  end

endmodule

// File: rtl/decode_pipe.sv
// Decode pipeline stage: ID output register with valid/ready handshake,
// RUN/HALTED control FSM, flush handling and load-use bubble insertion.
module decode_pipe
  import cpu_pkg::*;
#(
  parameter int PC_W      = 13,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_pc_plus2,
  input  logic [15:0]     if_inst,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            resume,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc_next,
  output logic [2:0]      id_rd_rq,
  output logic [2:0]      id_rs,
  output logic            id_write_en,
  output logic            id_jb,
  output logic            id_imm_sel,
  output logic            id_rs_or_imm,
  output logic [3:0]      id_alu_ctrl,
  output logic            id_mem_wr,
  output logic            id_mem_rd,
  output logic            halted
);

  id_ctrl_t        dec_ctrl_s;
  logic [PC_W-1:0] dec_pc_next_s;
  id_ctrl_t        ctrl_r;
  logic [PC_W-1:0] pc_next_r;
  logic            id_valid_r;
  pipe_state_e     state_r;
  pipe_state_e     state_next_s;
  logic            stall_s;
  logic            load_en_s;
  logic            transfer_s;
  logic            hazard_on_s;

  decode_ctrl #(.PC_W(PC_W)) u_decode_ctrl (
    .inst     (if_inst),
    .pc       (if_pc),
    .pc_plus2 (if_pc_plus2),
    .ctrl     (dec_ctrl_s),
    .pc_next  (dec_pc_next_s)
  );

  assign hazard_on_s = (HAZARD_EN != 0);

  // A load sitting in ID whose destination is read or named by the incoming
  // instruction holds fetch off until the load has left as a bubble.
  assign stall_s = hazard_on_s && id_valid_r && ctrl_r.mem_rd && ctrl_r.write_en &&
                   if_valid && ((dec_ctrl_s.rs == ctrl_r.rd_rq) ||
                                (dec_ctrl_s.rd_rq == ctrl_r.rd_rq));

  assign load_en_s  = !id_valid_r || ex_ready;
  assign if_ready   = rst_n && load_en_s && (state_r == ST_RUN) && !stall_s && !flush;
  assign transfer_s = if_valid && if_ready;

  // ID register: flush empties it, otherwise it refills whenever execute drains it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_r <= 1'b0;
      ctrl_r     <= '0;
      pc_next_r  <= '0;
    end else if (flush) begin
      id_valid_r <= 1'b0;
    end else if (load_en_s) begin
      id_valid_r <= transfer_s;
      if (transfer_s) begin
        ctrl_r    <= dec_ctrl_s;
        pc_next_r <= dec_pc_next_s;
      end
    end
  end

  // Pipeline state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Halt on issuing a halt instruction; leave on resume or any flush.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:    state_next_s = (transfer_s && (if_inst[15:12] == OP_HALT)) ? ST_HALTED : ST_RUN;
        ST_HALTED: state_next_s = resume ? ST_RUN : ST_HALTED;
        default:   state_next_s = ST_RUN;
      endcase
    end
  end

  assign id_valid     = id_valid_r;
  assign id_pc_next   = pc_next_r;
  assign id_rd_rq     = ctrl_r.rd_rq;
  assign id_rs        = ctrl_r.rs;
  assign id_write_en  = ctrl_r.write_en;
  assign id_jb        = ctrl_r.jb;
  assign id_imm_sel   = ctrl_r.imm_sel;
  assign id_rs_or_imm = ctrl_r.rs_or_imm;
  assign id_alu_ctrl  = ctrl_r.alu_ctrl;
  assign id_mem_wr    = ctrl_r.mem_wr;
  assign id_mem_rd    = ctrl_r.mem_rd;
  assign halted       = (state_r == ST_HALTED);

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench: two decode_pipe instances (hazard insertion on / off)
// share stimulus and are compared every cycle against a behavioural model.
module tb_decode_pipe;

  localparam int PC_W = 13;
  localparam int BW   = PC_W + 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, if_valid, ex_ready, flush, resume;
  logic [PC_W-1:0] if_pc, if_pc_plus2;
  logic [15:0]     if_inst;

  logic [1:0]          dut_ready, dut_valid, dut_halted;
  logic [1:0][BW-1:0]  dut_bundle;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [PC_W-1:0] pcn;
    logic [2:0]      rd, rs;
    logic [3:0]      alu;
    logic            rdy, vld, hlt, we, jb, imm, rsi, mw, mr;

    decode_pipe #(.PC_W(PC_W), .HAZARD_EN((g == 0) ? 1 : 0)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_valid     (if_valid),
      .if_ready     (rdy),
      .if_pc        (if_pc),
      .if_pc_plus2  (if_pc_plus2),
      .if_inst      (if_inst),
      .ex_ready     (ex_ready),
      .flush        (flush),
      .resume       (resume),
      .id_valid     (vld),
      .id_pc_next   (pcn),
      .id_rd_rq     (rd),
      .id_rs        (rs),
      .id_write_en  (we),
      .id_jb        (jb),
      .id_imm_sel   (imm),
      .id_rs_or_imm (rsi),
      .id_alu_ctrl  (alu),
      .id_mem_wr    (mw),
      .id_mem_rd    (mr),
      .halted       (hlt)
    );

    assign dut_ready[g]  = rdy;
    assign dut_valid[g]  = vld;
    assign dut_halted[g] = hlt;
    assign dut_bundle[g] = {pcn, rd, rs, we, jb, imm, rsi, alu, mw, mr};
  end

  // Bundle layout: pc_next | rd[15:13] | rs[12:10] | we[9] | jb[8] | imm[7] |
  // rs_or_imm[6] | alu[5:2] | mem_wr[1] | mem_rd[0]
  bit              m_known;
  bit              m_valid [2];
  bit              m_halted[2];
  logic [BW-1:0]   m_b     [2];
  bit              last_ready[2];
  int              n_vec  = 0;
  int              n_fail = 0;

  function automatic logic [BW-1:0] model_decode(input logic [PC_W-1:0] pc,
                                                 input logic [PC_W-1:0] pc2,
                                                 input logic [15:0] inst);
    int unsigned op;
    int unsigned sub;
    logic [3:0]  alu;
    logic [2:0]  rd;
    op  = inst[15:12];
    sub = inst[2:0];
    if (op >= 12)      alu = 4'(op - 12);
    else if (op == 11) alu = (sub == 0) ? 4'd8 : 4'(sub);
    else if (op == 10) alu = 4'(8 + sub);
    else               alu = 4'd0;
    rd = inst[14] ? inst[11:9] : inst[5:3];
    return {(op == 0) ? pc : pc2, rd, inst[8:6], inst[15],
            (op == 4 || op == 2), (op == 8 || op == 7), inst[13],
            alu, (op == 7), (op == 8)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare DUTs to the model, then advance the model.
  task automatic step(input bit rn, input bit iv, input logic [15:0] inst,
                      input logic [PC_W-1:0] pc, input bit exr,
                      input bit fl, input bit res);
    bit            nv[2], nh[2];
    logic [BW-1:0] nb[2];
    @(negedge clk);
    rst_n = rn; if_valid = iv; if_inst = inst; if_pc = pc;
    if_pc_plus2 = pc + 13'd2; ex_ready = exr; flush = fl; resume = res;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit stall, er, xfer;
      logic [2:0] ird;
      ird   = inst[14] ? inst[11:9] : inst[5:3];
      stall = (k == 0) && m_valid[k] && m_b[k][0] && m_b[k][9] && iv &&
              (inst[8:6] == m_b[k][15:13] || ird == m_b[k][15:13]);
      er    = rn && (!m_valid[k] || exr) && !m_halted[k] && !stall && !fl;
      xfer  = iv && er;
      last_ready[k] = dut_ready[k];
      if (!rn || m_known) chk($sformatf("if_ready[%0d]", k), 64'(dut_ready[k]), 64'(er));
      if (m_known) begin
        chk($sformatf("id_valid[%0d]", k), 64'(dut_valid[k]), 64'(m_valid[k]));
        chk($sformatf("halted[%0d]", k), 64'(dut_halted[k]), 64'(m_halted[k]));
        if (m_valid[k]) chk($sformatf("bundle[%0d]", k), 64'(dut_bundle[k]), 64'(m_b[k]));
      end
      nv[k] = m_valid[k]; nh[k] = m_halted[k]; nb[k] = m_b[k];
      if (!rn) begin
        nv[k] = 1'b0; nh[k] = 1'b0; nb[k] = '0;
      end else if (fl) begin
        nv[k] = 1'b0; nh[k] = 1'b0;
      end else begin
        if (!m_valid[k] || exr) nv[k] = xfer;
        if (xfer) nb[k] = model_decode(pc, pc + 13'd2, inst);
        if (xfer && inst[15:12] == 4'd0) nh[k] = 1'b1;
        else if (m_halted[k] && res)     nh[k] = 1'b0;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = nv[k]; m_halted[k] = nh[k]; m_b[k] = nb[k];
    end
    if (!rn) m_known = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_inst = 16'h0000; if_pc = '0;
    if_pc_plus2 = '0; ex_ready = 1'b0; flush = 1'b0; resume = 1'b0;
    m_known = 1'b0;

    // Reset with fetch presenting an instruction.
    step(1'b0, 1'b1, 16'hB000, 13'h000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'hB000, 13'h000, 1'b1, 1'b0, 1'b0);
    chk("rst_valid", 64'(dut_valid[0]), 64'd0);
    chk("rst_ready", 64'(last_ready[0]), 64'd0);
    chk("rst_halted", 64'(dut_halted[0]), 64'd0);
    chk("rst_bundle", 64'(dut_bundle[0]), 64'd0);

    // ALU register-group op with zero sub-op field.
    step(1'b1, 1'b1, 16'hB000, 13'h100, 1'b1, 1'b0, 1'b0);
    chk("b000_valid", 64'(dut_valid[0]), 64'd1);
    chk("b000_alu", 64'(dut_bundle[0][5:2]), 64'h8);
    chk("b000_rsi", 64'(dut_bundle[0][6]), 64'd1);
    chk("b000_we", 64'(dut_bundle[0][9]), 64'd1);
    chk("b000_pcn", 64'(dut_bundle[0][BW-1:16]), 64'h102);
    chk("model_alu", 64'(m_b[0][5:2]), 64'h8);

    // Load followed by a dependent instruction.
    step(1'b1, 1'b1, 16'h8400, 13'h200, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hA080, 13'h202, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_ready", 64'(last_ready[0]), 64'd0);
    chk("lu_bubble", 64'(dut_valid[0]), 64'd0);
    chk("nohz_ready", 64'(last_ready[1]), 64'd1);
    chk("nohz_valid", 64'(dut_valid[1]), 64'd1);
    chk("nohz_pcn", 64'(dut_bundle[1][BW-1:16]), 64'h204);
    step(1'b1, 1'b1, 16'hA080, 13'h202, 1'b1, 1'b0, 1'b0);
    chk("lu_issue_ready", 64'(last_ready[0]), 64'd1);
    chk("lu_issue_valid", 64'(dut_valid[0]), 64'd1);
    chk("lu_issue_alu", 64'(dut_bundle[0][5:2]), 64'h8);

    // Halt, stay halted, resume.
    step(1'b1, 1'b1, 16'h0000, 13'h010, 1'b1, 1'b0, 1'b0);
    chk("halt_valid", 64'(dut_valid[0]), 64'd1);
    chk("halt_pcn", 64'(dut_bundle[0][BW-1:16]), 64'h010);
    chk("halt_halted", 64'(dut_halted[0]), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 16'hB000, 13'h300, 1'b1, 1'b0, 1'b0);
      chk("halted_ready", 64'(last_ready[0]), 64'd0);
      chk("halted_valid", 64'(dut_valid[0]), 64'd0);
    end
    step(1'b1, 1'b1, 16'hB000, 13'h300, 1'b1, 1'b0, 1'b1);
    chk("resume_ready", 64'(last_ready[0]), 64'd0);
    chk("resume_run", 64'(dut_halted[0]), 64'd0);
    step(1'b1, 1'b1, 16'hB000, 13'h300, 1'b1, 1'b0, 1'b0);
    chk("run_ready", 64'(last_ready[0]), 64'd1);

    // Execute back-pressure on a load, then flush during the load-use stall.
    step(1'b1, 1'b1, 16'h8400, 13'h400, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 16'hA080, 13'h402, 1'b0, 1'b0, 1'b0);
      chk("bp_ready", 64'(last_ready[0]), 64'd0);
      chk("bp_valid", 64'(dut_valid[0]), 64'd1);
      chk("bp_bundle", 64'(dut_bundle[0]), 64'({13'h402, 16'h0281}));
    end
    step(1'b1, 1'b1, 16'hA080, 13'h402, 1'b0, 1'b1, 1'b0);
    chk("flush_ready", 64'(last_ready[0]), 64'd0);
    chk("flush_valid", 64'(dut_valid[0]), 64'd0);
    step(1'b1, 1'b1, 16'hA080, 13'h402, 1'b1, 1'b0, 1'b0);
    chk("post_flush_ready", 64'(last_ready[0]), 64'd1);

    // Flush together with resume while halted.
    step(1'b1, 1'b1, 16'h0000, 13'h500, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hC000, 13'h502, 1'b1, 1'b1, 1'b1);
    chk("fr_ready", 64'(last_ready[0]), 64'd0);
    chk("fr_halted", 64'(dut_halted[0]), 64'd0);
    chk("fr_valid", 64'(dut_valid[0]), 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] inst;
      int unsigned r;
      inst = 16'($urandom);
      r    = $urandom_range(0, 19);
      if (r < 5)       inst[15:12] = 4'b1000;
      else if (r == 5) inst[15:12] = 4'b0000;
      inst[11:9] = 3'($urandom_range(0, 3));
      inst[8:6]  = 3'($urandom_range(0, 3));
      inst[5:3]  = 3'($urandom_range(0, 3));
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8, inst,
           13'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
